// File: rtl/rv32_mem_pkg.sv
// rv32_mem_pkg: instruction-memory geometry and boot-loader state encoding
package rv32_mem_pkg;
  localparam int IMEM_DEPTH_WORDS = 1024;
  localparam int IMEM_BYTES       = 4096;
  localparam int WORD_BYTES       = 4;
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_HDR  = 3'd1;
  localparam state_t ST_LOAD = 3'd2;
  localparam state_t ST_RUN  = 3'd3;
  localparam state_t ST_ERR  = 3'd4;
  localparam state_t ST_CHK  = 3'd5;
endpackage

// File: rtl/imem_boot_loader_byte_to_word_packer.sv
// byte_to_word_packer: assembles little-endian bytes into 32-bit words; o_word_valid marks the 4th byte
module byte_to_word_packer
  import rv32_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);
  logic [1:0]  r_cnt;
  logic [23:0] r_word;
  assign o_word_valid = i_valid && (r_cnt == 2'(WORD_BYTES - 1));
  assign o_word       = {i_byte, r_word};
  // shift each byte in from the top so the first byte lands in [7:0] once four have arrived
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_valid) begin
      r_cnt  <= r_cnt + 2'd1;
      r_word <= o_word[31:8];
    end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads the instruction memory from a byte stream, then releases the core.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_boot_loader
  import rv32_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = IMEM_DEPTH_WORDS,
  parameter int AW          = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        core_rst_n,
  output logic        busy,
  output logic        done,
  output logic        error
);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t ST_END = ST_CHK;
`else
  localparam state_t ST_END = ST_RUN;
`endif
  state_t      r_state;
  logic [AW:0] r_n;
  logic [AW:0] r_widx;
  logic        r_we;
  logic        r_run;
  logic [31:0] r_waddr;
  logic [31:0] r_wdata;
  logic        w_rearm;
  logic        w_hs;
  logic        w_pack;
  logic        w_word_valid;
  logic        w_last;
  logic [31:0] w_word;
  assign w_rearm    = start && (r_state == ST_IDLE || r_state == ST_RUN || r_state == ST_ERR);
  assign busy       = r_state == ST_HDR || r_state == ST_LOAD || r_state == ST_CHK;
  assign rx_ready   = busy;
  assign w_hs       = rx_valid && rx_ready;
  assign w_pack     = w_hs && r_state != ST_CHK;
  assign w_last     = (r_widx + (AW+1)'(1)) == r_n;
  assign imem_we    = r_we;
  assign imem_waddr = r_waddr;
  assign imem_wdata = r_wdata;
  assign core_rst_n = r_run;
  assign done       = r_run;
  assign error      = r_state == ST_ERR;

  byte_to_word_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clr        (w_rearm),
    .i_valid      (w_pack),
    .i_byte       (rx_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_xor;
  // running XOR over every header and payload byte accepted this session
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_xor <= '0;
    else if (w_rearm) r_xor <= '0;
    else if (w_pack) r_xor <= r_xor ^ rx_data;
`endif

  // session sequencer: header decode, word writes, core release one cycle after reaching RUN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_n     <= '0;
      r_widx  <= '0;
      r_we    <= 1'b0;
      r_run   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we  <= 1'b0;
      r_run <= (r_state == ST_RUN) && !start;
      case (r_state)
        ST_IDLE, ST_RUN, ST_ERR:
          if (start) begin
            r_state <= ST_HDR;
            r_n     <= '0;
            r_widx  <= '0;
          end
        ST_HDR:
          if (w_word_valid) begin
            r_n     <= w_word[AW:0];
            r_state <= (w_word == '0) ? ST_END : (w_word > 32'(DEPTH_WORDS)) ? ST_ERR : ST_LOAD;
          end
        ST_LOAD:
          if (w_word_valid) begin
            r_we    <= 1'b1;
            r_waddr <= {{(30-AW){1'b0}}, r_widx[AW-1:0], 2'b00};
            r_wdata <= w_word;
            r_widx  <= r_widx + (AW+1)'(1);
            if (w_last) r_state <= ST_END;
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHK:
          if (w_hs) r_state <= (rx_data == r_xor) ? ST_RUN : ST_ERR;
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
endmodule
